css_mcu0_el2_ifu_parcel_align: RTL and testbench

Halfword parcel aligner in the MCU0 IFU, directly upstream of the compressed-instruction expander. It accepts 32-bit fetch words, queues them as 16-bit parcels, and finds instruction boundaries:
- a head parcel with bits [1:0] != 2'b11 is a 16-bit compressed instruction;
- otherwise the head parcel and the next parcel form one 32-bit instruction, which may straddle two fetch words.

Each cycle it presents at most one aligned instruction, with its PC, to decode. For compressed instructions it drives the raw 16 bits to the expander's `din`.

---
 rtl/css_mcu0_el2_pkg.sv | 16 +
 rtl/css_mcu0_el2_ifu_parcel_q.sv | 104 ++++++++++
 rtl/css_mcu0_el2_ifu_parcel_align.sv | 119 +++++++++++
 tb/tb_css_mcu0_el2_ifu_parcel_align.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/css_mcu0_el2_pkg.sv
// ---------------------------------------------------------------------------
// css_mcu0_el2_pkg
// Shared types for the MCU0 EL2 instruction fetch path.
//   EL2_PARCEL_W : width of one instruction parcel (halfword)
//   el2_parcel_t : one queued parcel, data plus fetch-fault flag
// ---------------------------------------------------------------------------
package css_mcu0_el2_pkg;

  localparam int unsigned EL2_PARCEL_W = 16;

  typedef struct packed {
    logic [EL2_PARCEL_W-1:0] data;
    logic                    err;
  } el2_parcel_t;

endpackage

// File: rtl/css_mcu0_el2_ifu_parcel_q.sv
// ---------------------------------------------------------------------------
// css_mcu0_el2_ifu_parcel_q
// Circular halfword parcel queue, 0/1/2 pushes and 0/1/2 pops per cycle.
// Exposes the two head parcels and the occupancy count.
// Optional macro: CSS_MCU0_ALIGN_ERR_EN stores the per-parcel error bit;
// otherwise the error field reads 0 and no error storage exists.
//
// Ports
//   clk, rst     : clock, synchronous active-high reset (clears storage too)
//   clr          : synchronous clear of pointers and count (storage kept)
//   push_n       : parcels to push this cycle (0..2)
//   push_a/b     : first / second parcel pushed (push_b only when push_n==2)
//   pop_n        : parcels to pop this cycle (0..2)
//   p0 / p1      : parcel at read pointer / read pointer + 1
//   count        : number of parcels held
// ---------------------------------------------------------------------------
module css_mcu0_el2_ifu_parcel_q
  import css_mcu0_el2_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic [1:0]               push_n,
  input  el2_parcel_t              push_a,
  input  el2_parcel_t              push_b,
  input  logic [1:0]               pop_n,
  output el2_parcel_t              p0,
  output el2_parcel_t              p1,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [PW:0] DEPTH_W = CW'(DEPTH);

  logic [EL2_PARCEL_W-1:0] r_data [DEPTH];
  logic [PW-1:0]           r_rd;
  logic [PW-1:0]           r_wr;
  logic [CW-1:0]           r_count;
  logic [PW-1:0]           w_rd1;
  logic [PW-1:0]           w_wr1;

  // Advance a pointer by 0..2 with explicit wrap, so non-power-of-2 depths work.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
    logic [PW:0] s;
    s = {1'b0, p} + CW'(n);
    if (s >= DEPTH_W) s = s - DEPTH_W;
    return s[PW-1:0];
  endfunction

  assign w_rd1 = ptr_add(r_rd, 2'd1);
  assign w_wr1 = ptr_add(r_wr, 2'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_data[i] <= '0;
    end else begin
      if (push_n != 2'd0) r_data[r_wr]  <= push_a.data;
      if (push_n == 2'd2) r_data[w_wr1] <= push_b.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      r_rd    <= ptr_add(r_rd, pop_n);
      r_wr    <= ptr_add(r_wr, push_n);
      r_count <= r_count + CW'(push_n) - CW'(pop_n);
    end
  end

`ifdef CSS_MCU0_ALIGN_ERR_EN
  logic r_err [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_err[i] <= 1'b0;
    end else begin
      if (push_n != 2'd0) r_err[r_wr]  <= push_a.err;
      if (push_n == 2'd2) r_err[w_wr1] <= push_b.err;
    end
  end

  assign p0.err = r_err[r_rd];
  assign p1.err = r_err[w_rd1];
`else
  logic w_unused_err;
  assign w_unused_err = push_a.err | push_b.err;
  assign p0.err = 1'b0;
  assign p1.err = 1'b0;
`endif

  assign p0.data = r_data[r_rd];
  assign p1.data = r_data[w_rd1];
  assign count   = r_count;

  a_count_bound: assert property (@(posedge clk) disable iff (rst) r_count <= DEPTH_W);

endmodule

// File: rtl/css_mcu0_el2_ifu_parcel_align.sv
// ---------------------------------------------------------------------------
// css_mcu0_el2_ifu_parcel_align
// Halfword parcel aligner: queues 32-bit fetch words as 16-bit parcels and
// presents at most one aligned instruction (16- or 32-bit) per cycle with PC.
// Optional macro: CSS_MCU0_ALIGN_ERR_EN enables per-parcel fault tracking;
// when undefined i0_err is tied to 0 and fetch_err is ignored.
//
// Parameters: PQ_DEPTH (4..8 halfwords), RST_PC (PC[31:1] after reset)
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   flush, flush_pc     : redirect, discards queue, loads PC[31:1]
//   fetch_valid/ready   : fetch word handshake
//   fetch_data          : fetch word, low halfword is earlier
//   fetch_hw_off        : only the upper halfword is valid
//   fetch_err           : fault on this fetch word
//   i0_valid/ready      : aligned instruction handshake
//   i0_instr            : instruction, upper half zero when compressed
//   i0_cinst            : head parcel for the compressed expander
//   i0_is_c, i0_pc      : compressed flag, PC[31:1]
//   i0_err              : fault on any consumed parcel
// ---------------------------------------------------------------------------
module css_mcu0_el2_ifu_parcel_align
  import css_mcu0_el2_pkg::*;
#(
  parameter int unsigned PQ_DEPTH = 4,
  parameter logic [30:0] RST_PC   = 31'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [30:0] flush_pc,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] fetch_data,
  input  logic        fetch_hw_off,
  input  logic        fetch_err,
  output logic        i0_valid,
  input  logic        i0_ready,
  output logic [31:0] i0_instr,
  output logic [15:0] i0_cinst,
  output logic        i0_is_c,
  output logic [30:0] i0_pc,
  output logic        i0_err
);

  localparam int unsigned CW = $clog2(PQ_DEPTH) + 1;

  logic [CW-1:0] w_count;
  el2_parcel_t   w_p0;
  el2_parcel_t   w_p1;
  el2_parcel_t   w_push_a;
  el2_parcel_t   w_push_b;
  logic [1:0]    w_push_n;
  logic [1:0]    w_pop_n;
  logic          w_nonempty;
  logic          w_p0_c;
  logic          w_fetch_fire;
  logic          w_pop;
  logic [30:0]   r_pc;

  css_mcu0_el2_ifu_parcel_q #(
    .DEPTH (PQ_DEPTH)
  ) u_q (
    .clk    (clk),
    .rst    (rst),
    .clr    (flush),
    .push_n (w_push_n),
    .push_a (w_push_a),
    .push_b (w_push_b),
    .pop_n  (w_pop_n),
    .p0     (w_p0),
    .p1     (w_p1),
    .count  (w_count)
  );

  // Ready looks only at the registered count; a same-cycle pop does not help.
  assign fetch_ready  = !flush && (w_count <= CW'(PQ_DEPTH - 2));
  assign w_fetch_fire = fetch_valid && fetch_ready;

  // With a half-word offset only the upper halfword enters the queue.
  assign w_push_a.data = fetch_hw_off ? fetch_data[31:16] : fetch_data[15:0];
  assign w_push_a.err  = fetch_err;
  assign w_push_b.data = fetch_data[31:16];
  assign w_push_b.err  = fetch_err;
  assign w_push_n      = !w_fetch_fire ? 2'd0 : (fetch_hw_off ? 2'd1 : 2'd2);

  // Head decode from registered queue state only.
  assign w_nonempty = (w_count != '0);
  assign w_p0_c     = (w_p0.data[1:0] != 2'b11);
  assign i0_valid   = w_nonempty && (w_p0_c || (w_count >= CW'(2)));
  assign i0_is_c    = w_nonempty && w_p0_c;
  assign i0_instr   = w_p0_c ? {16'h0, w_p0.data} : {w_p1.data, w_p0.data};
  assign i0_cinst   = w_p0.data;
  assign i0_pc      = r_pc;

  assign w_pop   = i0_valid && i0_ready && !flush;
  assign w_pop_n = !w_pop ? 2'd0 : (w_p0_c ? 2'd1 : 2'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RST_PC;
    end else if (flush) begin
      r_pc <= flush_pc;
    end else if (w_pop) begin
      r_pc <= r_pc + (w_p0_c ? 31'd1 : 31'd2);
    end
  end

`ifdef CSS_MCU0_ALIGN_ERR_EN
  assign i0_err = w_nonempty && (w_p0_c ? w_p0.err : (w_p0.err | w_p1.err));
`else
  logic w_unused_err;
  assign w_unused_err = fetch_err | w_p0.err | w_p1.err;
  assign i0_err = 1'b0;
`endif

  a_no_pop_invalid: assert property (@(posedge clk) disable iff (rst) (w_pop_n != 2'd0) |-> i0_valid);

endmodule

// File: tb/tb_css_mcu0_el2_ifu_parcel_align.sv
module tb_css_mcu0_el2_ifu_parcel_align;

`ifdef CSS_MCU0_ALIGN_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [30:0] flush_pc;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_data;
  logic        fetch_hw_off;
  logic        fetch_err;
  logic        i0_valid;
  logic        i0_ready;
  logic [31:0] i0_instr;
  logic [15:0] i0_cinst;
  logic        i0_is_c;
  logic [30:0] i0_pc;
  logic        i0_err;

  always #5 clk = ~clk;

  css_mcu0_el2_ifu_parcel_align #(
    .PQ_DEPTH (4),
    .RST_PC   (31'h100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .fetch_valid  (fetch_valid),
    .fetch_ready  (fetch_ready),
    .fetch_data   (fetch_data),
    .fetch_hw_off (fetch_hw_off),
    .fetch_err    (fetch_err),
    .i0_valid     (i0_valid),
    .i0_ready     (i0_ready),
    .i0_instr     (i0_instr),
    .i0_cinst     (i0_cinst),
    .i0_is_c      (i0_is_c),
    .i0_pc        (i0_pc),
    .i0_err       (i0_err)
  );

  typedef struct {
    logic [30:0] pc;
    logic [31:0] instr;
    logic        is_c;
    logic        err;
  } exp_t;

  typedef struct {
    logic        fv;
    logic [31:0] d;
    logic        rdy;
    logic        e_fr;
    logic        e_v;
    logic [30:0] e_pc;
  } vec_t;

  exp_t sb[$];
  vec_t tv[7];
  int   nchk = 0;
  int   nerr = 0;
  bit   sb_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic expect_instr(input logic [30:0] pc, input logic [31:0] instr,
                              input logic is_c, input logic err);
    exp_t e;
    e.pc = pc; e.instr = instr; e.is_c = is_c; e.err = err;
    sb.push_back(e);
  endtask

  // One clock: scoreboard check of any output handshake, then advance to
  // 1 time unit after the next rising edge.
  task automatic tick();
    exp_t e;
    #3;
    if (sb_on && i0_valid && i0_ready && !flush) begin
      nchk++;
      if (sb.size() == 0) begin
        nerr++;
        $display("FAIL sb_unexpected pc=%h instr=%h", i0_pc, i0_instr);
      end else begin
        e = sb.pop_front();
        if (i0_pc !== e.pc || i0_instr !== e.instr || i0_is_c !== e.is_c || i0_err !== e.err) begin
          nerr++;
          $display("FAIL sb_item actual pc=%h instr=%h c=%b err=%b expected pc=%h instr=%h c=%b err=%b",
                   i0_pc, i0_instr, i0_is_c, i0_err, e.pc, e.instr, e.is_c, e.err);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; fetch_valid = 1'b0; fetch_data = '0;
    fetch_hw_off = 1'b0; fetch_err = 1'b0;
  endtask

  task automatic do_flush(input logic [30:0] pc);
    idle_inputs();
    flush = 1'b1; flush_pc = pc;
    tick();
    flush = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    idle_inputs();
    i0_ready = 1'b1;
    while (sb.size() != 0 && n < 12) begin
      tick();
      n++;
    end
    chk({nm, "_drained"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  // Compressed 16'h4501 in word A low, 32-bit {0050,0513} straddling A/B,
  // then trailing compressed 16'h0000 from word B high.
  task automatic straddle(input string nm, input logic [30:0] pc, input logic err_b);
    do_flush(pc);
    expect_instr(pc,         32'h0000_4501, 1'b1, 1'b0);
    expect_instr(pc + 31'd1, 32'h0050_0513, 1'b0, err_b & ERR_EN);
    expect_instr(pc + 31'd3, 32'h0000_0000, 1'b1, err_b & ERR_EN);
    i0_ready = 1'b1;
    fetch_valid = 1'b1; fetch_data = 32'h0513_4501; fetch_err = 1'b0;
    tick();
    fetch_data = 32'h0000_0050; fetch_err = err_b;
    #1 chk({nm, "_b_ready"}, 32'(fetch_ready), 32'd1);
    tick();
    idle_inputs();
    #1;
    chk({nm, "_32_valid"}, 32'(i0_valid), 32'd1);
    chk({nm, "_32_is_c"},  32'(i0_is_c),  32'd0);
    chk({nm, "_32_cinst"}, 32'(i0_cinst), 32'h0513);
    tick();
    drain(nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Throttle sequence with PQ_DEPTH=4, all words two compressed c.nop parcels.
    tv[0] = '{fv:1'b1, d:32'h0001_0001, rdy:1'b0, e_fr:1'b1, e_v:1'b0, e_pc:31'h200};
    tv[1] = '{fv:1'b1, d:32'h0001_0001, rdy:1'b0, e_fr:1'b1, e_v:1'b1, e_pc:31'h200};
    tv[2] = '{fv:1'b1, d:32'h0001_0001, rdy:1'b0, e_fr:1'b0, e_v:1'b1, e_pc:31'h200};
    tv[3] = '{fv:1'b1, d:32'h0001_0001, rdy:1'b1, e_fr:1'b0, e_v:1'b1, e_pc:31'h200};
    tv[4] = '{fv:1'b1, d:32'h0001_0001, rdy:1'b1, e_fr:1'b0, e_v:1'b1, e_pc:31'h201};
    tv[5] = '{fv:1'b1, d:32'h0001_0001, rdy:1'b0, e_fr:1'b1, e_v:1'b1, e_pc:31'h202};
    tv[6] = '{fv:1'b0, d:32'h0000_0000, rdy:1'b0, e_fr:1'b0, e_v:1'b1, e_pc:31'h202};

    rst = 1'b1; flush_pc = '0; i0_ready = 1'b0;
    idle_inputs();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_valid", 32'(i0_valid), 32'd0);
    chk("rst_is_c",  32'(i0_is_c),  32'd0);
    chk("rst_instr", i0_instr,      32'd0);
    chk("rst_cinst", 32'(i0_cinst), 32'd0);
    chk("rst_err",   32'(i0_err),   32'd0);
    chk("rst_ready", 32'(fetch_ready), 32'd1);
    chk("rst_pc",    32'(i0_pc),    32'h100);

    // Two compressed instructions from one word, starting at RST_PC.
    sb_on = 1'b1;
    expect_instr(31'h100, 32'h0000_4501, 1'b1, 1'b0);
    expect_instr(31'h101, 32'h0000_0001, 1'b1, 1'b0);
    i0_ready = 1'b1;
    fetch_valid = 1'b1; fetch_data = 32'h0001_4501;
    tick();
    idle_inputs();
    #1 chk("c2_latency_valid", 32'(i0_valid), 32'd1);
    tick();
    drain("c2");

    straddle("strad", 31'h300, 1'b0);
    straddle("errb", 31'h80, 1'b1);

    // Queue-full throttling, checked per cycle from the table.
    sb_on = 1'b0;
    do_flush(31'h200);
    for (int unsigned i = 0; i < 7; i++) begin
      fetch_valid = tv[i].fv; fetch_data = tv[i].d; i0_ready = tv[i].rdy;
      #1;
      chk($sformatf("thr%0d_fetch_ready", i), 32'(fetch_ready), 32'(tv[i].e_fr));
      chk($sformatf("thr%0d_valid", i),       32'(i0_valid),    32'(tv[i].e_v));
      chk($sformatf("thr%0d_pc", i),          32'(i0_pc),       32'(tv[i].e_pc));
      tick();
    end

    // Flush colliding with a fetch and an output handshake: neither lands.
    flush = 1'b1; flush_pc = 31'h40; fetch_valid = 1'b1; fetch_data = 32'h0001_0001; i0_ready = 1'b1;
    #1;
    chk("fl_ready_low",   32'(fetch_ready), 32'd0);
    chk("fl_valid_before", 32'(i0_valid),   32'd1);
    tick();
    idle_inputs();
    #1;
    chk("fl_valid_after", 32'(i0_valid),    32'd0);
    chk("fl_pc_after",    32'(i0_pc),       32'h40);
    chk("fl_ready_after", 32'(fetch_ready), 32'd1);

    // Half-word offset: only the upper halfword is queued.
    sb_on = 1'b1;
    expect_instr(31'h40, 32'h0000_0001, 1'b1, 1'b0);
    fetch_valid = 1'b1; fetch_hw_off = 1'b1; fetch_data = 32'h0001_4501;
    tick();
    drain("hwoff");
    #1 chk("hwoff_empty_after", 32'(i0_valid), 32'd0);

    // PC[31:1] wraps to zero.
    do_flush(31'h7FFF_FFFF);
    expect_instr(31'h7FFF_FFFF, 32'h0000_0001, 1'b1, 1'b0);
    expect_instr(31'h0,         32'h0000_0001, 1'b1, 1'b0);
    fetch_valid = 1'b1; fetch_data = 32'h0001_0001;
    tick();
    drain("wrap");
    #1 chk("wrap_pc_final", 32'(i0_pc), 32'h1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
